// File: rtl/hqc_uart_cmd_ctrl_if.sv
// hqc_uart_cmd_ctrl_if: UART byte link, buffer port and decap core handshake bundle
interface hqc_uart_cmd_ctrl_if #(parameter int ADDR_W = 13);
    logic [7:0] rx_data;
    logic rx_valid;
    logic [7:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    logic ct_we;
    logic sk_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0] buf_wdata;
    logic ss_re;
    logic [ADDR_W-1:0] ss_addr;
    logic [7:0] ss_rdata;
    logic core_start;
    logic core_done;
    logic trig;
    logic busy;
    modport master (
        input rx_data, rx_valid, tx_ready, ss_rdata, core_done,
        output tx_data, tx_valid, ct_we, sk_we, buf_addr, buf_wdata, ss_re, ss_addr, core_start, trig, busy
    );
    modport slave (
        output rx_data, rx_valid, tx_ready, ss_rdata, core_done,
        input tx_data, tx_valid, ct_we, sk_we, buf_addr, buf_wdata, ss_re, ss_addr, core_start, trig, busy
    );
endinterface

// File: rtl/hqc_uart_cmd_ctrl.sv
// hqc_uart_cmd_ctrl: host command sequencer loading HQC decap buffers, running the core and returning the shared secret
module hqc_uart_cmd_ctrl #(
    parameter int CT_BYTES = 4433,
    parameter int SK_BYTES = 2305,
    parameter int SS_BYTES = 64,
    parameter int ADDR_W = 13,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input logic clk,
    input logic rst,
    hqc_uart_cmd_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, READ, RD_WAIT, SEND, REPLY} state_t;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    state_t state, state_nx;
    logic sel_ct, ct_ok, sk_ok;
    logic [ADDR_W-1:0] idx, ss_idx;
    logic [CNT_W-1:0] cnt;
    logic [7:0] status_nx;
    logic last_byte, timeout;
    assign last_byte = idx == (sel_ct ? ADDR_W'(CT_BYTES - 1) : ADDR_W'(SK_BYTES - 1));
    assign timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign bus.core_start = state == RUN;
    assign bus.trig = state == RUN || state == WAIT;
    assign bus.ss_re = state == READ;
    assign bus.ss_addr = ss_idx;
    assign bus.tx_valid = state == REPLY || state == SEND;
    assign bus.busy = state != IDLE;
    // state register; reset drops any operation in flight without a reply
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // command decode and sequencing; status_nx is the byte loaded on entry to REPLY
    always_comb begin
        state_nx = state;
        status_nx = 8'h00;
        case (state)
            IDLE: if (bus.rx_valid) begin
                case (bus.rx_data)
                    8'h01, 8'h02: state_nx = LOAD;
                    8'h03: begin
                        state_nx = (ct_ok && sk_ok) ? RUN : REPLY;
                        status_nx = 8'hE2;
                    end
                    8'h04: state_nx = READ;
                    default: begin
                        state_nx = REPLY;
                        status_nx = 8'hEE;
                    end
                endcase
            end
            LOAD: if (bus.rx_valid) begin
                if (last_byte) state_nx = REPLY;
            end else if (timeout) begin
                state_nx = REPLY;
                status_nx = 8'hE1;
            end
            RUN: state_nx = WAIT;
            WAIT: if (bus.core_done) state_nx = REPLY;
            READ: state_nx = RD_WAIT;
            RD_WAIT: state_nx = SEND;
            SEND: if (bus.tx_ready) state_nx = (ss_idx == ADDR_W'(SS_BYTES - 1)) ? IDLE : READ;
            REPLY: if (bus.tx_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // registered write port, load index and timeout counter, loaded flags, tx byte and secret read index
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_ct <= 1'b0;
            ct_ok <= 1'b0;
            sk_ok <= 1'b0;
            idx <= '0;
            ss_idx <= '0;
            cnt <= '0;
            bus.tx_data <= 8'h00;
            bus.ct_we <= 1'b0;
            bus.sk_we <= 1'b0;
            bus.buf_addr <= '0;
            bus.buf_wdata <= 8'h00;
        end else begin
            bus.ct_we <= 1'b0;
            bus.sk_we <= 1'b0;
            cnt <= cnt + 1'b1;
            if (state != REPLY && state_nx == REPLY) bus.tx_data <= status_nx;
            case (state)
                IDLE: if (bus.rx_valid && (bus.rx_data == 8'h01 || bus.rx_data == 8'h02)) begin
                    sel_ct <= bus.rx_data == 8'h01;
                    idx <= '0;
                    cnt <= '0;
                    if (bus.rx_data == 8'h01) ct_ok <= 1'b0;
                    else sk_ok <= 1'b0;
                end else if (bus.rx_valid && bus.rx_data == 8'h04) ss_idx <= '0;
                LOAD: if (bus.rx_valid) begin
                    bus.ct_we <= sel_ct;
                    bus.sk_we <= !sel_ct;
                    bus.buf_addr <= idx;
                    bus.buf_wdata <= bus.rx_data;
                    idx <= idx + 1'b1;
                    cnt <= '0;
                    if (last_byte && sel_ct) ct_ok <= 1'b1;
                    if (last_byte && !sel_ct) sk_ok <= 1'b1;
                end
                RD_WAIT: bus.tx_data <= bus.ss_rdata;
                SEND: if (bus.tx_ready) ss_idx <= ss_idx + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hqc_uart_cmd_ctrl.sv
// tb_hqc_uart_cmd_ctrl: randomized self-checking bench against a flag/queue reference model
module tb_hqc_uart_cmd_ctrl;
    localparam int CT = 4, SK = 3, SS = 2, AW = 4, TO = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0, n_pass = 0;
    int n_start = 0, n_trig = 0, n_we = 0, n_unstable = 0;
    logic [7:0] tx_q[$];
    logic [7:0] ss_mem [16];
    logic [7:0] ld [4];
    logic ct_ok_m = 1'b0, sk_ok_m = 1'b0;
    logic [7:0] prev_tx = 8'h00;
    logic prev_stall = 1'b0;
    hqc_uart_cmd_ctrl_if #(.ADDR_W(AW)) bus ();
    hqc_uart_cmd_ctrl #(
        .CT_BYTES(CT), .SK_BYTES(SK), .SS_BYTES(SS), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
    ) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // secret memory model: data valid exactly one cycle after a read strobe, junk otherwise
    always @(posedge clk) bus.ss_rdata <= bus.ss_re ? ss_mem[bus.ss_addr] : 8'hFF;
    // observe transfers, strobes and tx stability away from the active edge
    always @(negedge clk) begin
        if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
        if (prev_stall && bus.tx_valid && bus.tx_data != prev_tx) n_unstable++;
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_tx = bus.tx_data;
        n_start += 32'(bus.core_start);
        n_trig += 32'(bus.trig);
        n_we += 32'(bus.ct_we) + 32'(bus.sk_we);
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask
    task automatic wait_reply(input string tag, input logic [7:0] exp);
        int k = 0;
        while (tx_q.size() == 0 && k < 300) begin
            tick();
            k++;
        end
        if (tx_q.size() == 0) chk(tag, 32'h100, 32'(exp));
        else chk(tag, 32'(tx_q.pop_front()), 32'(exp));
    endtask
    task automatic load(input bit is_ct, input int n);
        int w0 = n_we;
        send_byte(is_ct ? 8'h01 : 8'h02);
        if (is_ct) ct_ok_m = 1'b0;
        else sk_ok_m = 1'b0;
        for (int i = 0; i < n; i++) begin
            send_byte(ld[i]);
            chk($sformatf("we%0d", i), 32'({bus.ct_we, bus.sk_we}), is_ct ? 32'h2 : 32'h1);
            chk($sformatf("addr%0d", i), 32'(bus.buf_addr), 32'(i));
            chk($sformatf("wdata%0d", i), 32'(bus.buf_wdata), 32'(ld[i]));
        end
        wait_reply("load_reply", 8'h00);
        chk("load_busy", 32'(bus.busy), 0);
        chk("load_strobes", 32'(n_we - w0), 32'(n));
        if (is_ct) ct_ok_m = 1'b1;
        else sk_ok_m = 1'b1;
    endtask
    task automatic rand_load(input bit is_ct);
        for (int i = 0; i < 4; i++) ld[i] = 8'($urandom);
        load(is_ct, is_ct ? CT : SK);
    endtask
    task automatic run_core(input int delay);
        int s0 = n_start;
        send_byte(8'h03);
        if (!(ct_ok_m && sk_ok_m)) begin
            chk("rej_start_trig", 32'({bus.core_start, bus.trig}), 0);
            wait_reply("run_rejected", 8'hE2);
            chk("rej_nstart", 32'(n_start - s0), 0);
            return;
        end
        n_trig = 0;
        chk("start_trig", 32'({bus.core_start, bus.trig}), 32'h3);
        tick();
        chk("start_one_cycle", 32'({bus.core_start, bus.trig}), 32'h1);
        send_byte(8'($urandom));
        tick(delay - 2);
        bus.core_done = 1'b1;
        chk("no_tx_before_done", 32'(bus.tx_valid), 0);
        tick();
        bus.core_done = 1'b0;
        chk("done_reply_trig", 32'({bus.tx_valid, bus.trig}), 32'h2);
        chk("trig_cycles", 32'(n_trig), 32'(delay + 1));
        wait_reply("run_reply", 8'h00);
        chk("nstart", 32'(n_start - s0), 1);
        tick(5);
        chk("run_no_extra_tx", 32'(tx_q.size()), 0);
    endtask
    task automatic read_rand();
        int k = 0;
        send_byte(8'h04);
        while (tx_q.size() < SS && k < 300) begin
            bus.tx_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        bus.tx_ready = 1'b1;
        for (int i = 0; i < SS; i++) wait_reply($sformatf("rand_ss%0d", i), ss_mem[i]);
        tick(8);
        chk("rand_read_extra", 32'(tx_q.size()), 0);
        chk("rand_read_busy", 32'(bus.busy), 0);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int k;
        logic [7:0] bad [5];
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        bus.core_done = 1'b0;
        for (int i = 0; i < 16; i++) ss_mem[i] = 8'($urandom);
        tick(3);
        chk("reset_outputs", 32'({bus.tx_valid, bus.tx_data, bus.ct_we, bus.sk_we, bus.buf_addr, bus.buf_wdata,
            bus.ss_re, bus.ss_addr, bus.core_start, bus.trig, bus.busy}), 0);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", 32'(bus.busy), 0);
        ld[0] = 8'hAA; ld[1] = 8'hBB; ld[2] = 8'hCC; ld[3] = 8'hDD;
        load(1'b1, CT);
        run_core(100);
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        tick(3);
        chk("idle_done_ignored", 32'({bus.busy, bus.tx_valid}), 0);
        rand_load(1'b0);
        run_core(100);
        ss_mem[0] = 8'h11;
        ss_mem[1] = 8'h22;
        bus.tx_ready = 1'b0;
        send_byte(8'h04);
        chk("rd_strobe", 32'({bus.ss_re, bus.ss_addr}), 32'h10);
        tick(2);
        chk("rd_first", 32'({bus.tx_valid, bus.tx_data}), 32'h111);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rd_stall%0d", i), 32'({bus.tx_valid, bus.tx_data}), 32'h111);
        end
        bus.tx_ready = 1'b1;
        wait_reply("rd_byte0", 8'h11);
        wait_reply("rd_byte1", 8'h22);
        tick(8);
        chk("rd_no_status", 32'(tx_q.size()), 0);
        for (int r = 0; r < 3; r++) begin
            ss_mem[0] = 8'($urandom);
            ss_mem[1] = 8'($urandom);
            read_rand();
        end
        send_byte(8'h02);
        sk_ok_m = 1'b0;
        send_byte(8'h55);
        k = 1;
        while (!bus.tx_valid && k < 40) begin
            tick();
            k++;
        end
        chk("timeout_latency", 32'(k), 17);
        wait_reply("timeout_reply", 8'hE1);
        run_core(10);
        send_byte(8'h02);
        send_byte(8'h31);
        tick(15);
        send_byte(8'h32);
        chk("race_byte_wins", 32'({bus.sk_we, bus.buf_addr, bus.buf_wdata}), 32'h11_32);
        tick(15);
        send_byte(8'h33);
        wait_reply("race_reply", 8'h00);
        sk_ok_m = 1'b1;
        for (int r = 0; r < 3; r++) begin
            rand_load(1'b1);
            rand_load(1'b0);
            run_core(int'($urandom_range(3, 40)));
        end
        bad[0] = 8'h7F; bad[1] = 8'h00; bad[2] = 8'hFF; bad[3] = 8'h05;
        bad[4] = 8'($urandom_range(5, 255));
        for (int i = 0; i < 5; i++) begin
            send_byte(bad[i]);
            wait_reply($sformatf("bad_cmd_%0h", bad[i]), 8'hEE);
            chk("bad_cmd_busy", 32'(bus.busy), 0);
        end
        send_byte(8'h01);
        send_byte(8'hAA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ct_ok_m = 1'b0;
        sk_ok_m = 1'b0;
        chk("midload_reset_outputs", 32'({bus.tx_valid, bus.tx_data, bus.ct_we, bus.sk_we, bus.buf_addr, bus.buf_wdata,
            bus.ss_re, bus.ss_addr, bus.core_start, bus.trig, bus.busy}), 0);
        tick(10);
        chk("midload_no_reply", 32'(tx_q.size()), 0);
        run_core(10);
        chk("tx_stability", 32'(n_unstable), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
